// File: rtl/noc_axi_pkg.sv
// Shared types for the AXI4-Lite slave responder.
//   resp_t     : AXI response codes used on BRESP/RRESP
//   wr_state_t : write-channel FSM states
//   rd_state_t : read-channel FSM states
package noc_axi_pkg;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axil_resp_regfile.sv
// DEPTH x 32-bit register array behind the AXI4-Lite responder.
// Ports:
//   clk, rst         clock, asynchronous active-low clear (all words to 0)
//   we, widx         write enable and word index
//   wdata, wstrb     write data and byte enables (byte i written iff wstrb[i])
//   re, rhit, ridx   read strobe, address-hit flag, word index
//   rdata            registered read data; loads 0 on a strobe with rhit=0,
//                    otherwise holds its value between strobes
module axil_resp_regfile #(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic             re,
    input  logic             rhit,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // A read and a write to the same word on one edge returns the old word,
    // since the array update is non-blocking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rhit ? mem[ridx] : '0;
        end
    end

endmodule

// File: rtl/axil_slave_responder_mem.sv
// AXI4-Lite slave responder: word-addressed register window at BASE_ADDR.
// One outstanding write and one outstanding read, run by independent FSMs.
// Accesses outside [BASE_ADDR, BASE_ADDR+4*DEPTH) answer SLVERR; such
// writes change nothing and such reads return 0.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   awaddr/awprot/awvalid/awready   write address channel (awprot ignored)
//   wdata/wstrb/wvalid/wready       write data channel
//   bresp/bvalid/bready             write response channel
//   araddr/arprot/arvalid/arready   read address channel (arprot ignored)
//   rdata/rresp/rvalid/rready       read data channel
// All ready/valid outputs come straight from flops.
module axil_slave_responder_mem
    import noc_axi_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h7000_0000,
    parameter int              DEPTH     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready
);

    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4 * DEPTH);

    // ---------------- write path ----------------
    wr_state_t         wr_state, wr_state_n;
    logic              aw_held, w_held, aw_held_n, w_held_n;
    logic              awready_n, wready_n, bvalid_n, wr_commit;
    logic [ADDR_W-1:0] awaddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    resp_t             bresp_q;

    logic              aw_hs, w_hs, wr_hit;
    logic [ADDR_W-1:0] wr_addr, wr_off;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        wr_strb;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    // The commit edge may be the same edge that captures AW or W, so take the
    // live bus value for whichever channel is handshaking right now.
    assign wr_addr = aw_hs ? awaddr : awaddr_q;
    assign wr_data = w_hs  ? wdata  : wdata_q;
    assign wr_strb = w_hs  ? wstrb  : wstrb_q;
    assign wr_off  = wr_addr - BASE_ADDR;
    assign wr_hit  = (wr_addr >= BASE_ADDR) && (wr_off < SPAN);

    always_comb begin
        wr_state_n = wr_state;
        aw_held_n  = aw_held;
        w_held_n   = w_held;
        awready_n  = awready;
        wready_n   = wready;
        bvalid_n   = bvalid;
        wr_commit  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                aw_held_n = aw_held | aw_hs;
                w_held_n  = w_held | w_hs;
                if (aw_held_n && w_held_n) begin
                    wr_commit  = 1'b1;
                    bvalid_n   = 1'b1;
                    awready_n  = 1'b0;
                    wready_n   = 1'b0;
                    wr_state_n = W_RESP;
                end else begin
                    awready_n = !aw_held_n;
                    wready_n  = !w_held_n;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_n   = 1'b0;
                    aw_held_n  = 1'b0;
                    w_held_n   = 1'b0;
                    awready_n  = 1'b1;
                    wready_n   = 1'b1;
                    wr_state_n = W_IDLE;
                end
            end
            default: wr_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp_q  <= AXI_RESP_OKAY;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            wr_state <= wr_state_n;
            aw_held  <= aw_held_n;
            w_held   <= w_held_n;
            awready  <= awready_n;
            wready   <= wready_n;
            bvalid   <= bvalid_n;
            if (aw_hs) awaddr_q <= awaddr;
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (wr_commit) bresp_q <= wr_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        end
    end

    assign bresp = bresp_q;

    // ---------------- read path ----------------
    rd_state_t         rd_state, rd_state_n;
    logic              arready_n, rvalid_n, rd_en, ar_hs, rd_hit;
    logic [ADDR_W-1:0] rd_off;
    resp_t             rresp_q;

    assign ar_hs  = arvalid & arready;
    assign rd_off = araddr - BASE_ADDR;
    assign rd_hit = (araddr >= BASE_ADDR) && (rd_off < SPAN);

    always_comb begin
        rd_state_n = rd_state;
        arready_n  = arready;
        rvalid_n   = rvalid;
        rd_en      = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_en      = 1'b1;
                    rvalid_n   = 1'b1;
                    arready_n  = 1'b0;
                    rd_state_n = R_RESP;
                end else begin
                    arready_n = 1'b1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_n   = 1'b0;
                    arready_n  = 1'b1;
                    rd_state_n = R_IDLE;
                end
            end
            default: rd_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rresp_q  <= AXI_RESP_OKAY;
        end else begin
            rd_state <= rd_state_n;
            arready  <= arready_n;
            rvalid   <= rvalid_n;
            if (rd_en) rresp_q <= rd_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        end
    end

    assign rresp = rresp_q;

    axil_resp_regfile #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_commit & wr_hit),
        .widx  (wr_off[IDX_W+1:2]),
        .wdata (wr_data),
        .wstrb (wr_strb),
        .re    (rd_en),
        .rhit  (rd_hit),
        .ridx  (rd_off[IDX_W+1:2]),
        .rdata (rdata)
    );

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{awprot, arprot, wr_off[1:0], rd_off[1:0]};

endmodule

// File: tb/tb_axil_slave_responder_mem.sv
// Randomized + directed bench for axil_slave_responder_mem with a
// queue-based scoreboard and an array reference model of the register window.
module tb_axil_slave_responder_mem;

    localparam logic [31:0] BASE  = 32'h7000_0000;
    localparam int          DEPTH = 16;
    localparam logic [1:0]  OKAY  = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic [1:0]  b_exp_q[$];
    rexp_t       r_exp_q[$];
    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    axil_slave_responder_mem dut (
        .clk     (clk),
        .rst     (rst_n),
        .awaddr  (awaddr),
        .awprot  (awprot),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arprot  (arprot),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s timed out t=%0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_hit(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        if (!m_hit(a)) return;
        idx = m_idx(a);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    function automatic rexp_t m_read(input logic [31:0] a);
        rexp_t e;
        if (m_hit(a)) begin
            e.data = model_mem[m_idx(a)];
            e.resp = OKAY;
        end else begin
            e.data = 32'h0;
            e.resp = SLVERR;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 16) return BASE + 32'(4 * r) + 32'($urandom_range(0, 3));
        if (r < 18) return BASE + 32'(4 * DEPTH) + 32'(4 * (r - 16));
        if (r == 18) return BASE - 32'd4;
        return 32'hF000_0000;
    endfunction

    // ---------------- scoreboard monitor ----------------
    bit          pb_pend = 0, pr_pend = 0;
    logic [1:0]  pb_resp, pr_resp;
    logic [31:0] pr_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            pb_pend = 0;
            pr_pend = 0;
        end else begin
            if (pb_pend) begin
                check("bvalid_hold", 32'(bvalid), 32'd1);
                check("bresp_hold", 32'(bresp), 32'(pb_resp));
            end
            if (pr_pend) begin
                check("rvalid_hold", 32'(rvalid), 32'd1);
                check("rdata_hold", rdata, pr_data);
                check("rresp_hold", 32'(rresp), 32'(pr_resp));
            end
            if (bvalid && bready) begin
                if (b_exp_q.size() == 0) begin
                    check("b_unexpected", 32'(b_exp_q.size()), 32'd1);
                end else begin
                    logic [1:0] e;
                    e = b_exp_q.pop_front();
                    check("sb_bresp", 32'(bresp), 32'(e));
                end
            end
            if (rvalid && rready) begin
                if (r_exp_q.size() == 0) begin
                    check("r_unexpected", 32'(r_exp_q.size()), 32'd1);
                end else begin
                    rexp_t e;
                    e = r_exp_q.pop_front();
                    check("sb_rdata", rdata, e.data);
                    check("sb_rresp", 32'(rresp), 32'(e.resp));
                end
            end
            pb_pend = bvalid && !bready;
            pb_resp = bresp;
            pr_pend = rvalid && !rready;
            pr_data = rdata;
            pr_resp = rresp;
        end
    end

    // ---------------- drivers ----------------
    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] got_resp);
        bit aw_done, w_done, ok_aw, ok_w, ok_b;
        aw_done = 0; w_done = 0; ok_aw = 0; ok_w = 0; ok_b = 0;
        got_resp = 2'bxx;
        fork
            begin
                repeat (aw_dly) @(posedge clk);
                #1 awaddr = addr; awvalid = 1'b1;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (w_done) check("wready_low_after_w", 32'(wready), 32'd0);
                    if (awvalid && awready) begin ok_aw = 1; break; end
                end
                if (!ok_aw) timeout("aw_handshake");
                @(posedge clk);
                #1 awvalid = 1'b0; aw_done = 1;
            end
            begin
                repeat (w_dly) @(posedge clk);
                #1 wdata = data; wstrb = strb; wvalid = 1'b1;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (aw_done) check("awready_low_after_aw", 32'(awready), 32'd0);
                    if (wvalid && wready) begin ok_w = 1; break; end
                end
                if (!ok_w) timeout("w_handshake");
                @(posedge clk);
                #1 wvalid = 1'b0; w_done = 1;
            end
        join
        if (!(ok_aw && ok_w)) return;
        m_write(addr, data, strb);
        b_exp_q.push_back(m_hit(addr) ? OKAY : SLVERR);
        check("b_latency", 32'(bvalid), 32'd1);
        repeat (b_dly) begin
            @(negedge clk);
            check("bvalid_wait", 32'(bvalid), 32'd1);
            check("no_aw_in_resp", 32'(awready), 32'd0);
            check("no_w_in_resp", 32'(wready), 32'd0);
            @(posedge clk);
            #1;
        end
        bready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bvalid && bready) begin ok_b = 1; got_resp = bresp; break; end
        end
        if (!ok_b) timeout("b_handshake");
        @(posedge clk);
        #1 bready = 1'b0;
        check("awready_after_b", 32'(awready), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] got_data, output logic [1:0] got_resp);
        bit ok_ar, ok_r;
        ok_ar = 0; ok_r = 0;
        got_data = 'x; got_resp = 2'bxx;
        repeat (ar_dly) @(posedge clk);
        #1 araddr = addr; arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arvalid && arready) begin
                // Sampled before the accepting edge, so a write committing on
                // that same edge is not yet visible: the read sees the old word.
                r_exp_q.push_back(m_read(addr));
                ok_ar = 1;
                break;
            end
        end
        if (!ok_ar) begin timeout("ar_handshake"); arvalid = 1'b0; return; end
        @(posedge clk);
        #1 arvalid = 1'b0;
        check("r_latency", 32'(rvalid), 32'd1);
        check("arready_in_resp", 32'(arready), 32'd0);
        repeat (r_dly) begin
            @(negedge clk);
            check("rvalid_wait", 32'(rvalid), 32'd1);
            @(posedge clk);
            #1;
        end
        rready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rvalid && rready) begin ok_r = 1; got_data = rdata; got_resp = rresp; break; end
        end
        if (!ok_r) timeout("r_handshake");
        @(posedge clk);
        #1 rready = 1'b0;
        check("arready_after_r", 32'(arready), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_awready"}, 32'(awready), 32'd0);
        check({tag, "_wready"}, 32'(wready), 32'd0);
        check({tag, "_arready"}, 32'(arready), 32'd0);
        check({tag, "_bvalid"}, 32'(bvalid), 32'd0);
        check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        check({tag, "_bresp"}, 32'(bresp), 32'd0);
        check({tag, "_rresp"}, 32'(rresp), 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  br, rr;
        logic [31:0] rd;
        bit          ok;

        rst_n = 1'b0;
        awaddr = '0; awprot = 3'b000; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

        #3 check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // basic write then read-back
        do_write(BASE + 32'h0, 32'h1100_0011, 4'hF, 0, 0, 0, br); check("t1_bresp0", 32'(br), 32'(OKAY));
        do_write(BASE + 32'h4, 32'h2200_0022, 4'hF, 0, 0, 1, br); check("t1_bresp1", 32'(br), 32'(OKAY));
        do_write(BASE + 32'h8, 32'h3300_0033, 4'hF, 1, 0, 0, br); check("t1_bresp2", 32'(br), 32'(OKAY));
        do_read(BASE + 32'h0, 0, 0, rd, rr); check("t1_rdata0", rd, 32'h1100_0011); check("t1_rresp0", 32'(rr), 32'(OKAY));
        do_read(BASE + 32'h4, 0, 2, rd, rr); check("t1_rdata1", rd, 32'h2200_0022);
        do_read(BASE + 32'h8, 1, 0, rd, rr); check("t1_rdata2", rd, 32'h3300_0033);

        // byte-lane write
        do_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, br);
        do_write(BASE + 32'hC, 32'h0000_AB00, 4'b0010, 0, 0, 0, br);
        do_read(BASE + 32'hC, 0, 0, rd, rr); check("t2_strobe", rd, 32'hFFFF_ABFF);

        // one past the window
        do_write(BASE + 32'h40, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, br); check("t3_bresp", 32'(br), 32'(SLVERR));
        do_read(BASE + 32'h40, 0, 0, rd, rr);
        check("t3_rresp", 32'(rr), 32'(SLVERR)); check("t3_rdata", rd, 32'h0);
        do_read(BASE + 32'h0, 0, 0, rd, rr); check("t3_word0_kept", rd, 32'h1100_0011);
        do_read(BASE - 32'h4, 0, 0, rd, rr); check("t3_below_rresp", 32'(rr), 32'(SLVERR));

        // W three cycles ahead of AW, B held off five cycles
        do_write(BASE + 32'h10, 32'h4444_4444, 4'hF, 3, 0, 5, br); check("t4_bresp", 32'(br), 32'(OKAY));
        do_read(BASE + 32'h10, 0, 0, rd, rr); check("t4_rdata", rd, 32'h4444_4444);

        // same-edge write commit and read of one word
        fork
            do_write(BASE + 32'h4, 32'h0000_0005, 4'hF, 0, 0, 0, br);
            do_read(BASE + 32'h4, 0, 0, rd, rr);
        join
        check("t5_old_value", rd, 32'h2200_0022);
        do_read(BASE + 32'h4, 0, 0, rd, rr); check("t5_new_value", rd, 32'h0000_0005);

        // randomized concurrent traffic
        fork
            begin
                logic [1:0] wb;
                for (int i = 0; i < 40; i++) begin
                    do_write(rand_addr(), $urandom(), 4'($urandom_range(0, 15)),
                             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                             int'($urandom_range(0, 3)), wb);
                end
            end
            begin
                logic [31:0] xd;
                logic [1:0]  xr;
                for (int i = 0; i < 40; i++) begin
                    do_read(rand_addr(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), xd, xr);
                end
            end
        join

        // reset while a read response is stalled
        araddr = BASE + 32'h8; arvalid = 1'b1; rready = 1'b0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arvalid && arready) begin ok = 1; break; end
        end
        if (!ok) timeout("t6_ar");
        @(posedge clk);
        #1 arvalid = 1'b0;
        check("t6_rvalid_before", 32'(rvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("t6_rvalid_dropped", 32'(rvalid), 32'd0);
        check_outputs_zero("t6");
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_read(BASE + 32'h0, 0, 0, rd, rr); check("t6_word0", rd, 32'h0);
        do_read(BASE + 32'h8, 0, 0, rd, rr); check("t6_word2", rd, 32'h0);
        do_read(BASE + 32'h3C, 0, 0, rd, rr); check("t6_word15", rd, 32'h0); check("t6_rresp", 32'(rr), 32'(OKAY));

        repeat (2) @(posedge clk);
        #1;
        check("b_queue_drained", 32'(b_exp_q.size()), 32'd0);
        check("r_queue_drained", 32'(r_exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
